// File: rtl/comparador_multimodo.sv
// Pipelined multi-mode comparator: six compare modes, valid/ready flow control
// with a global stall, and a saturating tally of transferred true results.
module comparador_multimodo #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             output_s,
    output logic             eq_flag,
    output logic             lt_flag,
    input  logic             count_clr,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [2:0] MODE_EQ  = 3'b000;
    localparam logic [2:0] MODE_NE  = 3'b001;
    localparam logic [2:0] MODE_LTS = 3'b010;
    localparam logic [2:0] MODE_GES = 3'b011;
    localparam logic [2:0] MODE_LTU = 3'b100;
    localparam logic [2:0] MODE_GEU = 3'b101;

    logic en;

    // Stage 1: registered operands and mode
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_mode_q, s1_mode_d;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_a_d     = input_a;
            s1_b_d     = input_b;
            s1_mode_d  = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
        end
    end

    // Compare logic, evaluated on the stage-1 registers only
    logic eq_c, lt_s_c, lt_u_c, lt_c, s_c;

    always_comb begin
        eq_c   = (s1_a_q == s1_b_q);
        lt_s_c = ($signed(s1_a_q) < $signed(s1_b_q));
        lt_u_c = (s1_a_q < s1_b_q);
        lt_c   = s1_mode_q[2] ? lt_u_c : lt_s_c;
        case (s1_mode_q)
            MODE_EQ:  s_c = eq_c;
            MODE_NE:  s_c = !eq_c;
            MODE_LTS: s_c = lt_s_c;
            MODE_GES: s_c = !lt_s_c;
            MODE_LTU: s_c = lt_u_c;
            MODE_GEU: s_c = !lt_u_c;
            default:  s_c = 1'b0;
        endcase
    end

    generate
        if (STAGES == 1) begin : g_direct
            // Gate by valid so the reset/bubble state reads as all-zero
            assign out_valid = s1_valid_q;
            assign output_s  = s1_valid_q & s_c;
            assign eq_flag   = s1_valid_q & eq_c;
            assign lt_flag   = s1_valid_q & lt_c;
        end else begin : g_pipe
            localparam int N = STAGES - 1;
            logic v_q  [N];
            logic v_d  [N];
            logic s_q  [N];
            logic s_d  [N];
            logic eq_q [N];
            logic eq_d [N];
            logic lt_q [N];
            logic lt_d [N];

            always_comb begin
                for (int i = 0; i < N; i++) begin
                    v_d[i]  = v_q[i];
                    s_d[i]  = s_q[i];
                    eq_d[i] = eq_q[i];
                    lt_d[i] = lt_q[i];
                end
                if (en) begin
                    v_d[0]  = s1_valid_q;
                    s_d[0]  = s_c;
                    eq_d[0] = eq_c;
                    lt_d[0] = lt_c;
                    for (int i = 1; i < N; i++) begin
                        v_d[i]  = v_q[i-1];
                        s_d[i]  = s_q[i-1];
                        eq_d[i] = eq_q[i-1];
                        lt_d[i] = lt_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < N; i++) begin
                    if (rst) begin
                        v_q[i]  <= 1'b0;
                        s_q[i]  <= 1'b0;
                        eq_q[i] <= 1'b0;
                        lt_q[i] <= 1'b0;
                    end else begin
                        v_q[i]  <= v_d[i];
                        s_q[i]  <= s_d[i];
                        eq_q[i] <= eq_d[i];
                        lt_q[i] <= lt_d[i];
                    end
                end
            end

            assign out_valid = v_q[N-1];
            assign output_s  = s_q[N-1];
            assign eq_flag   = eq_q[N-1];
            assign lt_flag   = lt_q[N-1];
        end
    endgenerate

    // Saturating count of true results; clear wins over increment
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && output_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;

endmodule
